// File: rtl/print_bus_pkg.sv
// Shared types and constants for the print bus master.
package print_bus_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned BEAT_W = 8;

    localparam logic [BE_W-1:0]   BE_ALL     = 4'hF;
    localparam logic [DATA_W-1:0] PRINT_BASE = 32'h6000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEGIN,
        ST_DATA,
        ST_END
    } state_t;

    // Registered bus payload; all-zero whenever the master is not driving.
    typedef struct packed {
        logic [DATA_W-1:0] addrData;
        logic [BE_W-1:0]   byteEnables;
        logic [BEAT_W-1:0] burstSize;
        logic              beginTransaction;
        logic              endTransaction;
        logic              dataValid;
    } busDrive_t;

endpackage

// File: rtl/print_burst_master_if.sv
// Producer stream plus shared-bus signals of the print burst master.
interface print_burst_master_if;
    import print_bus_pkg::*;

    logic [DATA_W-1:0] in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              bus_request_o;
    logic              bus_grant_i;
    logic              bus_busy_i;
    logic [DATA_W-1:0] bus_addrData_o;
    logic [BE_W-1:0]   bus_byteEnables_o;
    logic [BEAT_W-1:0] bus_burstSize_o;
    logic              bus_readNWrite_o;
    logic              bus_beginTransaction_o;
    logic              bus_endTransaction_o;
    logic              bus_dataValid_o;

    modport master (
        input  in_data_i, in_valid_i, bus_grant_i, bus_busy_i,
        output in_ready_o, bus_request_o, bus_addrData_o, bus_byteEnables_o,
               bus_burstSize_o, bus_readNWrite_o, bus_beginTransaction_o,
               bus_endTransaction_o, bus_dataValid_o
    );

    modport slave (
        output in_data_i, in_valid_i, bus_grant_i, bus_busy_i,
        input  in_ready_o, bus_request_o, bus_addrData_o, bus_byteEnables_o,
               bus_burstSize_o, bus_readNWrite_o, bus_beginTransaction_o,
               bus_endTransaction_o, bus_dataValid_o
    );

endinterface

// File: rtl/print_fifo.sv
// Synchronous word FIFO with head and head+1 peek for registered bus drive.
module print_fifo
    import print_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DATA_W-1:0]              wrData,
    output logic [DATA_W-1:0]              head,
    output logic [DATA_W-1:0]              nextHead,
    output logic                           ready,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  countNext;

    assign head     = mem[rdPtr];
    assign nextHead = mem[rdPtr + PTR_W'(1)];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign countNext = count + CNT_W'(push) - CNT_W'(pop);

    // Storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers, occupancy and a registered ready that stays low through reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            ready <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= countNext;
            ready <= (countNext != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/print_burst_master.sv
// Buffers producer words and writes them to the print slave as single-address bursts.
module print_burst_master
    import print_bus_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR    = PRINT_BASE,
    parameter int unsigned       FIFO_DEPTH   = 16,
    parameter int unsigned       MAX_BURST    = 8,
    parameter int unsigned       IDLE_TIMEOUT = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    print_burst_master_if.master bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TMR_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned LEN_W = $clog2(MAX_BURST + 1);

    state_t            state;
    busDrive_t         drive;
    logic              request;
    logic [TMR_W-1:0]  timer;
    logic [LEN_W-1:0]  lenReg;
    logic [LEN_W-1:0]  beats;
    logic [LEN_W-1:0]  lenNow;

    logic              push;
    logic              pop;
    logic              goReq;
    logic              lastBeat;
    logic              fifoReady;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] nextHead;

    print_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .push     (push),
        .pop      (pop),
        .wrData   (bus.in_data_i),
        .head     (head),
        .nextHead (nextHead),
        .ready    (fifoReady),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (count)
    );

    assign push     = bus.in_valid_i && fifoReady;
    assign pop      = (state == ST_DATA) && !bus.bus_busy_i;
    assign goReq    = (count >= CNT_W'(MAX_BURST)) ||
                      (!fifoEmpty && (timer == TMR_W'(IDLE_TIMEOUT - 1)));
    assign lastBeat = (beats == lenReg - LEN_W'(1));

    // Burst length captured at grant: whatever is buffered, capped at MAX_BURST.
    always_comb begin
        lenNow = LEN_W'(MAX_BURST);
        if (count < CNT_W'(MAX_BURST)) begin
            lenNow = LEN_W'(count);
        end
    end

    assign bus.in_ready_o             = fifoReady;
    assign bus.bus_request_o          = request;
    assign bus.bus_addrData_o         = drive.addrData;
    assign bus.bus_byteEnables_o      = drive.byteEnables;
    assign bus.bus_burstSize_o        = drive.burstSize;
    assign bus.bus_readNWrite_o       = 1'b0;
    assign bus.bus_beginTransaction_o = drive.beginTransaction;
    assign bus.bus_endTransaction_o   = drive.endTransaction;
    assign bus.bus_dataValid_o        = drive.dataValid;

    // Age of a partial buffer; only runs while idle with a sub-burst amount queued.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            timer <= '0;
        end else if (push || (state != ST_IDLE) || fifoEmpty || goReq) begin
            timer <= '0;
        end else if (count < CNT_W'(MAX_BURST)) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Burst FSM; outputs are loaded with the values for the state being entered.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            drive   <= '0;
            request <= 1'b0;
            lenReg  <= '0;
            beats   <= '0;
        end else begin
            drive   <= '0;
            request <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (goReq) begin
                        state   <= ST_REQ;
                        request <= 1'b1;
                    end
                end
                ST_REQ: begin
                    request <= 1'b1;
                    if (bus.bus_grant_i) begin
                        state                  <= ST_BEGIN;
                        lenReg                 <= lenNow;
                        beats                  <= '0;
                        drive.beginTransaction <= 1'b1;
                        drive.addrData         <= BASE_ADDR;
                        drive.burstSize        <= BEAT_W'(lenNow - LEN_W'(1));
                        drive.byteEnables      <= BE_ALL;
                    end
                end
                ST_BEGIN: begin
                    state           <= ST_DATA;
                    request         <= 1'b1;
                    drive.dataValid <= 1'b1;
                    drive.addrData  <= head;
                end
                ST_DATA: begin
                    if (pop && lastBeat) begin
                        state                <= ST_END;
                        drive.endTransaction <= 1'b1;
                    end else begin
                        request         <= 1'b1;
                        drive.dataValid <= 1'b1;
                        drive.addrData  <= pop ? nextHead : head;
                        if (pop) begin
                            beats <= beats + LEN_W'(1);
                        end
                    end
                end
                ST_END: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Arbiter must hold grant from begin through end.
    grantHeld: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (state inside {ST_BEGIN, ST_DATA, ST_END}) |-> bus.bus_grant_i);

    // A push is never presented to a full FIFO.
    noOverflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push && fifoFull));

endmodule
